// File: rtl/icb_flash_copier.sv
`default_nettype none
// ============================================================================
// Module   : icb_flash_copier
// Brief    : Word-by-word memory copier over a single ICB master port.
//            Each word is read from src, then written to dst. Only one ICB
//            transaction is outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module icb_flash_copier #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic [31:0]      icb_cmd_addr,
    output logic             icb_cmd_read,
    output logic [31:0]      icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [31:0]      icb_rsp_rdata,
    input  logic             icb_rsp_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CMD = 3'd1,
        ST_RD_RSP = 3'd2,
        ST_WR_CMD = 3'd3,
        ST_WR_RSP = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_count;
    logic             r_err;

    logic w_load;       // accepted start with a non-zero length
    logic w_clr_err;    // any accepted start clears the sticky error
    logic w_rd_take;    // read response consumed this cycle
    logic w_wr_take;    // write response consumed this cycle
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_set_err;
    logic w_last;

    assign w_last = (r_count == LEN_W'(1));
    assign err    = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, ICB command/response drive and datapath strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_clr_err     = 1'b0;
        w_rd_take     = 1'b0;
        w_wr_take     = 1'b0;
        w_rd_ok       = 1'b0;
        w_wr_ok       = 1'b0;
        w_set_err     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr_err = 1'b1;
                    if (len_words == '0) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RD_CMD;
                    end
                end
            end
            ST_RD_CMD: begin
                busy          = 1'b1;
                icb_rsp_ready = 1'b1;
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'b1;
                icb_cmd_addr  = r_src;
                // A response seen without our handshake cannot belong to us
                if (icb_cmd_ready) begin
                    if (icb_rsp_valid) begin
                        w_rd_take = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD_RSP;
                    end
                end
            end
            ST_RD_RSP: begin
                busy          = 1'b1;
                icb_rsp_ready = 1'b1;
                w_rd_take     = icb_rsp_valid;
            end
            ST_WR_CMD: begin
                busy          = 1'b1;
                icb_rsp_ready = 1'b1;
                icb_cmd_valid = 1'b1;
                icb_cmd_addr  = r_dst;
                icb_cmd_wdata = r_data;
                icb_cmd_wmask = 4'hF;
                if (icb_cmd_ready) begin
                    if (icb_rsp_valid) begin
                        w_wr_take = 1'b1;
                    end else begin
                        w_state_nxt = ST_WR_RSP;
                    end
                end
            end
            ST_WR_RSP: begin
                busy          = 1'b1;
                icb_rsp_ready = 1'b1;
                w_wr_take     = icb_rsp_valid;
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Response resolution is shared by the command and response states
        if (w_rd_take) begin
            if (icb_rsp_err) begin
                w_set_err   = 1'b1;
                w_state_nxt = ST_FIN;
            end else begin
                w_rd_ok     = 1'b1;
                w_state_nxt = ST_WR_CMD;
            end
        end
        if (w_wr_take) begin
            if (icb_rsp_err) begin
                w_set_err   = 1'b1;
                w_state_nxt = ST_FIN;
            end else begin
                w_wr_ok     = 1'b1;
                w_state_nxt = w_last ? ST_FIN : ST_RD_CMD;
            end
        end
    end

    // Address pointers, remaining count, data buffer and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_src   <= src_addr & 32'hFFFF_FFFC;
                r_dst   <= dst_addr & 32'hFFFF_FFFC;
                r_count <= len_words;
            end
            if (w_rd_ok) begin
                r_data <= icb_rsp_rdata;
            end
            if (w_wr_ok) begin
                r_src   <= r_src + 32'd4;
                r_dst   <= r_dst + 32'd4;
                r_count <= r_count - LEN_W'(1);
            end
            if (w_clr_err) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icb_flash_copier.sv
`default_nettype none
// ============================================================================
// Module   : tb_icb_flash_copier
// Brief    : Self-checking bench for icb_flash_copier. A reference model
//            builds the expected ICB command stream per copy; a monitor pops
//            and compares it on every command handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icb_flash_copier;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic             busy, done, err;
    logic             icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0]      icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]       icb_cmd_wmask;
    logic             icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0]      icb_rsp_rdata;

    icb_flash_copier #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source memory contents: a fixed scramble of the word address
    function automatic logic [31:0] src_word(input logic [31:0] a, input logic [31:0] sd);
        return (a * 32'h9E37_79B1) ^ sd ^ 32'h0F0F_1234;
    endfunction

    // ---------------- responder ----------------
    int          mode;      // 0: zero-wait combinational, 1: random stalls/delays
    bit          hold_rsp;  // withhold write responses
    bit          no_stall;
    int          err_at;    // 1-based read index that returns an error, 0 = none
    logic [31:0] seed;
    logic        r1_cmd_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_rdata;

    assign icb_cmd_ready = (mode == 0) ? icb_rsp_ready : r1_cmd_ready;
    assign icb_rsp_valid = (mode == 0) ? icb_cmd_valid : r1_rsp_valid;
    assign icb_rsp_rdata = (mode == 0) ? src_word(icb_cmd_addr, seed) : r1_rdata;
    assign icb_rsp_err   = (mode == 0) ? 1'b0 : r1_rsp_err;

    initial begin
        bit          pend, p_rd, p_err, hs, racc, smp_rd;
        int          p_dly, rd_n;
        logic [31:0] p_addr, smp_addr;
        pend = 0; p_rd = 0; p_err = 0; p_dly = 0; rd_n = 0; p_addr = '0;
        r1_cmd_ready = 0; r1_rsp_valid = 0; r1_rsp_err = 0; r1_rdata = '0;
        forever begin
            @(negedge clk);
            hs       = icb_cmd_valid && icb_cmd_ready;
            racc     = icb_rsp_valid && icb_rsp_ready;
            smp_rd   = icb_cmd_read;
            smp_addr = icb_cmd_addr;
            if (start) rd_n = 0;
            @(posedge clk); #1;
            if (rst || mode != 1) begin
                pend = 0; r1_rsp_valid = 0; r1_rsp_err = 0; r1_cmd_ready = 0;
            end else begin
                if (racc) begin r1_rsp_valid = 0; r1_rsp_err = 0; end
                if (hs) begin
                    pend = 1; p_rd = smp_rd; p_addr = smp_addr;
                    p_dly = $urandom_range(0, 3);
                    if (smp_rd) begin rd_n++; p_err = (rd_n == err_at); end
                    else p_err = 0;
                end
                if (pend && !r1_rsp_valid && !(hold_rsp && !p_rd)) begin
                    if (p_dly == 0) begin
                        r1_rsp_valid = 1;
                        r1_rsp_err   = p_err;
                        r1_rdata     = p_rd ? src_word(p_addr, seed) : $urandom;
                        pend         = 0;
                    end else begin
                        p_dly--;
                    end
                end
                r1_cmd_ready = no_stall || ($urandom_range(0, 2) != 0);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    cmd_t exp_q[$];

    // Checks command hold during stalls and pops one expectation per handshake
    initial begin
        bit   stall;
        cmd_t held, act, e;
        stall = 0; held = '0;
        forever begin
            @(negedge clk);
            act = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
            if (rst) begin
                stall = 0;
            end else begin
                if (stall)
                    chk(icb_cmd_valid && act == held, "cmd_hold", {icb_cmd_valid, act}, {1'b1, held});
                if (icb_cmd_valid && icb_cmd_ready) begin
                    chk(exp_q.size() != 0, "unexpected_cmd", act, '0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        if (act.rd) act.wdata = '0;   // read data bus is don't-care
                        chk(act == e, "cmd", act, e);
                    end
                end
                stall = icb_cmd_valid && !icb_cmd_ready;
                held  = act;
            end
        end
    end

    // ---------------- one copy with model-built expectations ----------------
    task automatic run_copy(input string tag, input int md, input logic [31:0] src,
                            input logic [31:0] dst, input int len, input int eat, input bit chk_lat);
        logic [31:0] s, d;
        int          s_cyc, b_cyc, d_cyc, d_cnt, budget;
        bit          d_err, exp_err;
        mode = md; err_at = eat; seed = $urandom;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        exp_err = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b1, s + 32'(4 * i), 32'h0, 4'h0});
            if (i + 1 == eat) begin exp_err = 1; break; end
            exp_q.push_back({1'b0, d + 32'(4 * i), src_word(s + 32'(4 * i), seed), 4'hF});
        end
        @(posedge clk); #1;
        src_addr = src; dst_addr = dst; len_words = LEN_W'(len); start = 1;
        @(posedge clk); #1;
        start = 0;
        s_cyc = cyc; b_cyc = -1; d_cyc = -1; d_cnt = 0; d_err = 0;
        budget = 60 * len + 40;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy && b_cyc < 0) b_cyc = cyc;
            if (done) begin
                d_cnt++;
                if (d_cyc < 0) begin d_cyc = cyc; d_err = err; end
            end
            if (d_cyc >= 0 && cyc - d_cyc >= 4) break;
        end
        if (d_cyc < 0) $display("FAIL %s_timeout: got no done expected done within %0d cycles", tag, budget);
        chk(d_cnt == 1, {tag, "_done_count"}, 72'(d_cnt), 72'd1);
        chk(d_err == exp_err, {tag, "_err_at_done"}, 72'(d_err), 72'(exp_err));
        chk(err == exp_err, {tag, "_err_held"}, 72'(err), 72'(exp_err));
        chk(exp_q.size() == 0, {tag, "_cmds_missing"}, 72'(exp_q.size()), 72'd0);
        if (len == 0) begin
            chk(b_cyc < 0, {tag, "_busy_never"}, 72'(b_cyc), 72'hFF_FFFF_FFFF_FFFF_FFFF);
            chk(d_cyc == s_cyc, {tag, "_done_lat"}, 72'(d_cyc - s_cyc), 72'd0);
        end
        if (chk_lat) begin
            chk(b_cyc == s_cyc, {tag, "_busy_lat"}, 72'(b_cyc - s_cyc), 72'd0);
            chk(d_cyc - b_cyc == 2 * len, {tag, "_done_lat"}, 72'(d_cyc - b_cyc), 72'(2 * len));
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        cmd_t e0;
        rst = 1; start = 0; src_addr = '0; dst_addr = '0; len_words = '0;
        mode = 0; hold_rsp = 0; no_stall = 0; err_at = 0; seed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({busy, done, err} == 3'b000, "reset_status", {busy, done, err}, 0);
        chk({icb_cmd_valid, icb_rsp_ready} == 2'b00, "reset_hs", {icb_cmd_valid, icb_rsp_ready}, 0);
        chk({icb_cmd_addr, icb_cmd_wdata, icb_cmd_read, icb_cmd_wmask} == '0, "reset_cmd",
            {icb_cmd_addr, icb_cmd_wdata, icb_cmd_read, icb_cmd_wmask}, 0);
        @(posedge clk); #1;
        rst = 0;

        run_copy("basic", 0, 32'h2000_0000, 32'h8000_0000, 4, 0, 1);
        run_copy("zero_len", 0, 32'h2000_0000, 32'h8000_0000, 0, 0, 0);
        run_copy("zw_unaligned", 0, 32'h1000_0003, 32'h3000_0002, 5, 0, 1);
        run_copy("stall16", 1, 32'h4000_0100, 32'h5000_0000, 16, 0, 0);
        run_copy("rd_err", 1, 32'h4000_0000, 32'h5000_0000, 8, 3, 0);
        run_copy("after_err", 0, 32'h0000_1000, 32'h0000_2000, 2, 0, 1);
        run_copy("wrap", 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 0, 0);
        run_copy("wrap_zw", 0, 32'hFFFF_FFF8, 32'h0000_0010, 3, 0, 1);
        for (int k = 0; k < 6; k++) begin
            int l, ea;
            l  = $urandom_range(1, 12);
            ea = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_copy("rand", 1, $urandom, $urandom, l, ea, 0);
        end

        // Reset while a write response is outstanding
        mode = 1; hold_rsp = 1; no_stall = 1; err_at = 0; seed = $urandom;
        e0 = {1'b1, 32'h6000_0000, 32'h0, 4'h0};
        exp_q.push_back(e0);
        exp_q.push_back({1'b0, 32'h7000_0000, src_word(32'h6000_0000, seed), 4'hF});
        @(posedge clk); #1;
        src_addr = 32'h6000_0000; dst_addr = 32'h7000_0000; len_words = 16'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (icb_cmd_valid && icb_cmd_ready && !icb_cmd_read) seen = 1;
        end
        chk(seen, "rst_wr_reached", 72'(seen), 72'd1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk(busy && !icb_cmd_valid, "rst_in_wr_rsp", {busy, icb_cmd_valid}, 72'b10);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk({icb_cmd_valid, busy, icb_rsp_ready, done} == 4'b0000, "rst_effect",
            {icb_cmd_valid, busy, icb_rsp_ready, done}, 0);
        hold_rsp = 0; no_stall = 0;
        exp_q.delete();
        run_copy("post_rst", 1, 32'h6000_0040, 32'h7000_0040, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
